// File: rtl/ram_dma_pkg.sv
// Shared types and defaults for the RAM-to-RAM copy engine.
package ram_dma_pkg;

    localparam int unsigned AW_DEF = 13;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } dma_state_t;

endpackage

// File: rtl/ram_dma_copy.sv
// Word-copy DMA initiator for a single-port synchronous RAM: alternating read/write cycles.
// Optional XOR checksum of copied words when RAM_DMA_CKSUM_EN is defined.
module ram_dma_copy
    import ram_dma_pkg::*;
#(
    parameter int unsigned AW   = AW_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned LENW = AW + 1
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            start,
    input  logic [AW-1:0]   src_addr,
    input  logic [AW-1:0]   dst_addr,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   cksum,
    output logic            ram_cs_b,
    output logic            ram_rnw,
    output logic [AW-1:0]   ram_address,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);

    dma_state_t      state;
    dma_state_t      state_n;
    logic [AW-1:0]   src_q;
    logic [AW-1:0]   src_n;
    logic [AW-1:0]   dst_q;
    logic [AW-1:0]   dst_n;
    logic [LENW-1:0] rem_q;
    logic [LENW-1:0] rem_n;
    logic [AW-1:0]   addr_n;
    logic [DW-1:0]   din_q;

    // Next-state and pointer/count update
    always_comb begin
        state_n = state;
        src_n   = src_q;
        dst_n   = dst_q;
        rem_n   = rem_q;
        case (state)
            IDLE: begin
                if (start) begin
                    src_n   = src_addr;
                    dst_n   = dst_addr;
                    rem_n   = len;
                    state_n = (len == '0) ? FIN : RD;
                end
            end
            RD: begin
                state_n = WR;
            end
            WR: begin
                src_n   = src_q + AW'(1);
                dst_n   = dst_q + AW'(1);
                rem_n   = rem_q - LENW'(1);
                state_n = (rem_n != '0) ? RD : FIN;
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Address for the upcoming bus cycle; holds outside RD/WR
    always_comb begin
        addr_n = ram_address;
        if (state_n == RD) begin
            addr_n = src_n;
        end else if (state_n == WR) begin
            addr_n = dst_n;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state       <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            din_q       <= '0;
            ram_cs_b    <= 1'b1;
            ram_rnw     <= 1'b1;
            ram_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            src_q       <= src_n;
            dst_q       <= dst_n;
            rem_q       <= rem_n;
            ram_cs_b    <= !((state_n == RD) || (state_n == WR));
            ram_rnw     <= (state_n != WR);
            ram_address <= addr_n;
            busy        <= (state_n == RD) || (state_n == WR);
            done        <= (state_n == FIN);
            if (state == WR) begin
                din_q <= ram_dout;
            end
        end
    end

    // Read data arrives during WR, so write data bypasses straight from the RAM and is then held
    assign ram_din = (state == WR) ? ram_dout : din_q;

`ifdef RAM_DMA_CKSUM_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cksum <= '0;
        end else if ((state == IDLE) && start) begin
            cksum <= '0;
        end else if (state == WR) begin
            cksum <= cksum ^ ram_dout;
        end
    end
`else
    assign cksum = '0;
`endif

endmodule
